// File: rtl/trng_health_fifo.sv
// Continuous RCT/APT health tests on the raw TRNG byte stream, with startup
// gating, alarm handling and a small valid/ready output FIFO.
module trng_health_fifo #(
  parameter int unsigned RCT_CUTOFF      = 4,
  parameter int unsigned APT_WINDOW      = 512,
  parameter int unsigned APT_CUTOFF      = 13,
  parameter int unsigned STARTUP_SAMPLES = 1024,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] raw_byte,
  input  logic       raw_valid,
  input  logic       clear_alarm,
  output logic [7:0] random_byte,
  output logic       random_valid,
  input  logic       random_ready,
  output logic       health_ok,
  output logic       rct_fail,
  output logic       apt_fail,
  output logic [7:0] drop_cnt
);

  localparam int unsigned RCT_W = 4;
  localparam int unsigned POS_W = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
  localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);
  localparam int unsigned ST_W  = $clog2(STARTUP_SAMPLES + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_ALARM} state_e;

  state_e             state_q, state_d;
  logic               have_last_q;
  logic [7:0]         last_q, ref_q;
  logic [RCT_W-1:0]   rct_cnt_q, rct_next;
  logic [APT_W-1:0]   apt_cnt_q, apt_next;
  logic [POS_W-1:0]   pos_q;
  logic [ST_W-1:0]    startup_cnt_q;
  logic               clr_c, accept_c, rct_hit, apt_hit, fail_c, start_done;
  logic               push_c, flush_c, health_ok_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      rd_q, wr_q, rd_n;
  logic [CW-1:0]      count_q, count_n, remain;
  logic               pop_c, full_c, wr_en_c, drop_c;
  logic [7:0]         head_n;

  // A clear only acts in ALARM, and then it swallows any coincident sample.
  assign clr_c    = clear_alarm && (state_q == ST_ALARM);
  assign accept_c = raw_valid && !clr_c;

  // Health-test evaluation of the current sample against the stored history.
  always_comb begin
    rct_next = RCT_W'(1);
    if (have_last_q && (raw_byte == last_q))
      rct_next = (rct_cnt_q == {RCT_W{1'b1}}) ? rct_cnt_q : rct_cnt_q + RCT_W'(1);
    apt_next = (pos_q == '0) ? APT_W'(1) : apt_cnt_q + APT_W'(raw_byte == ref_q);
  end

  assign rct_hit    = rct_next >= RCT_W'(RCT_CUTOFF);
  assign apt_hit    = apt_next >= APT_W'(APT_CUTOFF);
  assign fail_c     = accept_c && (rct_hit || apt_hit);
  assign start_done = startup_cnt_q == ST_W'(STARTUP_SAMPLES - 1);

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= ST_STARTUP;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP: if (fail_c) state_d = ST_ALARM;
                  else if (accept_c && start_done) state_d = ST_RUN;
      ST_RUN:     if (fail_c) state_d = ST_ALARM;
      ST_ALARM:   if (clr_c) state_d = ST_STARTUP;
      default:    state_d = ST_STARTUP;
    endcase
  end

  // FSM outputs: FIFO push/flush control and the next health_ok.
  always_comb begin
    push_c      = 1'b0;
    flush_c     = 1'b0;
    health_ok_d = 1'b0;
    push_c      = (state_q == ST_RUN) && accept_c && !fail_c;
    flush_c     = (state_d == ST_ALARM) && (state_q != ST_ALARM);
    health_ok_d = (state_d == ST_RUN);
  end

  // Health-test history, sticky flags and startup sample count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      have_last_q   <= 1'b0;
      last_q        <= '0;
      ref_q         <= '0;
      rct_cnt_q     <= '0;
      apt_cnt_q     <= '0;
      pos_q         <= '0;
      startup_cnt_q <= '0;
      rct_fail      <= 1'b0;
      apt_fail      <= 1'b0;
      health_ok     <= 1'b0;
    end else begin
      health_ok <= health_ok_d;
      if (clr_c) begin
        have_last_q   <= 1'b0;
        rct_cnt_q     <= '0;
        apt_cnt_q     <= '0;
        pos_q         <= '0;
        startup_cnt_q <= '0;
        rct_fail      <= 1'b0;
        apt_fail      <= 1'b0;
      end else if (accept_c) begin
        have_last_q <= 1'b1;
        last_q      <= raw_byte;
        rct_cnt_q   <= rct_next;
        apt_cnt_q   <= apt_next;
        if (pos_q == '0) ref_q <= raw_byte;
        pos_q       <= pos_q + POS_W'(1);
        rct_fail    <= rct_fail | rct_hit;
        apt_fail    <= apt_fail | apt_hit;
        if (state_q == ST_STARTUP) startup_cnt_q <= startup_cnt_q + ST_W'(1);
      end
    end
  end

  assign pop_c   = random_valid && random_ready;
  assign full_c  = count_q == CW'(FIFO_DEPTH);
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && full_c && !pop_c;

  // Next FIFO head; a push into an otherwise empty FIFO becomes the head directly.
  always_comb begin
    rd_n    = rd_q + AW'(pop_c);
    remain  = count_q - CW'(pop_c);
    count_n = remain + CW'(wr_en_c);
    head_n  = (remain == '0) ? raw_byte : mem_q[rd_n];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_q] <= raw_byte;
  end

  // FIFO pointers, registered head/valid and the saturating drop counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      random_valid <= 1'b0;
      random_byte  <= '0;
      drop_cnt     <= '0;
    end else begin
      if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (flush_c) begin
        rd_q         <= '0;
        wr_q         <= '0;
        count_q      <= '0;
        random_valid <= 1'b0;
      end else begin
        if (wr_en_c) wr_q <= wr_q + AW'(1);
        rd_q         <= rd_n;
        count_q      <= count_n;
        random_valid <= (count_n != '0);
        if (count_n != '0) random_byte <= head_n;
      end
    end
  end

endmodule

// File: doc/trng_health_fifo.md
Name: trng_health_fifo

Overview:
- Sits directly downstream of the trng entropy block and consumes its raw random byte stream.
- Runs the two continuous health tests, the Repetition Count Test (RCT) and the Adaptive Proportion Test (APT), on every sample.
- Discards output during a startup qualification period and after any test failure.
- Buffers qualified bytes in a small FIFO with a valid/ready interface for the downstream consumer.

Parameters:
- RCT_CUTOFF, 4: a run of identical consecutive samples reaching this length is a failure (range 2..15).
- APT_WINDOW, 512: APT window length in samples (power of two, at most 1024).
- APT_CUTOFF, 13: the reference value occurring this many times in one window is a failure.
- STARTUP_SAMPLES, 1024: number of samples tested but not delivered after reset or clear.
- FIFO_DEPTH, 4: output FIFO entries (power of two, at least 2).

Ports:
- clk, input, 1: single clock, rising edge.
- n_reset, input, 1: asynchronous active-low reset.
- raw_byte, input, 8: sample from the trng.
- raw_valid, input, 1: raw_byte is new this cycle. The source cannot be stalled.
- clear_alarm, input, 1: single-cycle pulse. Leaves ALARM and restarts STARTUP.
- random_byte, output, 8: FIFO head.
- random_valid, output, 1: FIFO not empty.
- random_ready, input, 1: consumer pops the head when random_valid and random_ready are both high.
- health_ok, output, 1: high only in state RUN.
- rct_fail, output, 1: sticky RCT failure flag.
- apt_fail, output, 1: sticky APT failure flag.
- drop_cnt, output, 8: saturating count of samples dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, n_reset low):
  - State = STARTUP; all counters, flags and FIFO pointers cleared.
  - Outputs: random_byte=0, random_valid=0, health_ok=0, rct_fail=0, apt_fail=0, drop_cnt=0.
- Sample acceptance: a sample is accepted on every clk edge where raw_valid=1. Nothing happens on cycles where raw_valid=0.
- RCT, evaluated on each accepted sample:
  - If the sample equals the last sample, rct_cnt++. Otherwise rct_cnt=1 and last=sample.
  - The first sample after reset or clear sets rct_cnt=1.
  - rct_cnt reaching RCT_CUTOFF sets rct_fail.
- APT, evaluated on each accepted sample:
  - At window position 0, ref=sample and apt_cnt=1.
  - At other positions, apt_cnt++ if the sample equals ref.
  - The position counter wraps from APT_WINDOW-1 to 0.
  - apt_cnt reaching APT_CUTOFF sets apt_fail.
- Flag timing: both flags are registered and visible the cycle after the failing sample.
- State machine:
  - STARTUP: counts accepted samples. After STARTUP_SAMPLES samples with no failure, go to RUN. A failure goes to ALARM.
  - RUN: each accepted, non-failing sample is pushed into the FIFO.
  - ALARM: entered on any failure. On entry, the FIFO is flushed in the same edge, so random_valid=0 on the next cycle. No pushes occur while in ALARM.
- Failing sample: a sample that triggers a failure is never pushed.
- Leaving ALARM:
  - Only clear_alarm or reset leaves ALARM.
  - clear_alarm clears both flags, rct_cnt, apt_cnt, the window position and the startup counter, then enters STARTUP.
  - drop_cnt is not cleared by clear_alarm.
  - clear_alarm in any state other than ALARM is ignored.
  - clear_alarm arriving together with raw_valid: the clear wins and that sample is discarded untested.
- FIFO:
  - Push-to-output latency is 1 cycle: a sample pushed on edge N gives random_valid=1 after edge N.
  - If full and no pop this cycle, the pushed sample is dropped and drop_cnt increments, saturating at 255.
  - If full with a simultaneous pop, the push is accepted.
  - Empty with a simultaneous push and ready: no same-cycle bypass.
  - random_byte holds its value while random_valid=0.
- Reset mid-operation: abandons any partial window, FIFO contents and flags immediately.

Test Plan:
- Startup gating: after reset, feed 1024 distinct incrementing samples, all with raw_valid=1 -> random_valid stays 0 and health_ok=0 throughout; health_ok=1 the cycle after the 1024th sample; the 1025th sample appears on random_byte one cycle after it is accepted.
- RCT: in RUN, feed 0x5A four times consecutively -> rct_fail=1 the cycle after the 4th sample; the FIFO is flushed; the 4th 0x5A is never output. Three 0x5A followed by 0x5B -> no failure.
- APT: in RUN, feed a window whose first sample is 0x11, with 0x11 recurring at positions 40,80,...,480 (13 occurrences in total) -> apt_fail=1 at the 13th occurrence. With only 12 occurrences -> no failure, and the counters restart at the next window.
- Clear: in ALARM, pulse clear_alarm -> flags=0 and the block is back in STARTUP; exactly 1024 further samples are needed before health_ok=1.
- Clear with a sample: pulse clear_alarm in the same cycle as raw_valid=1 -> that sample is not counted toward STARTUP_SAMPLES.
- Backpressure: in RUN with random_ready=0, push 6 samples -> 4 are buffered and drop_cnt=2. Then drive random_ready=1 while pushing continuously -> bytes are delivered in order with no further drops.
- Async reset mid-run: assert n_reset between clock edges -> all outputs go to 0 immediately, without waiting for clk.
